// File: rtl/para.sv
// Shared flit format: width, header field size and flit-type encodings.
package para;
  localparam int FLIT_SIZE  = 16;
  localparam int HEADER_LEN = 3;

  localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 3'b001;
  localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 3'b010;
  localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 3'b011;
  localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 3'b100;
endpackage

// File: rtl/flit_frame_checker.sv
// Packet framing tracker: accepts only well-ordered HEAD/BODY/TAIL/SINGLE flits,
// flags anything else with a registered one-cycle drop pulse.
module flit_frame_checker
  import para::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HEADER_LEN-1:0] flit_type,
  input  logic                  xfer,
  output logic                  accept,
  output logic                  err_drop
);
  typedef enum logic {FR_IDLE, FR_IN_PKT} frame_state_e;

  frame_state_e state, state_nxt;
  logic         legal;

  always_comb begin
    legal     = 1'b0;
    state_nxt = state;
    case (state)
      FR_IDLE: begin
        if (flit_type == HEAD_FLIT) begin
          legal     = 1'b1;
          state_nxt = FR_IN_PKT;
        end else if (flit_type == SINGLE_FLIT) begin
          legal = 1'b1;
        end
      end
      FR_IN_PKT: begin
        if (flit_type == BODY_FLIT) begin
          legal = 1'b1;
        end else if (flit_type == TAIL_FLIT) begin
          legal     = 1'b1;
          state_nxt = FR_IDLE;
        end
      end
      default: state_nxt = FR_IDLE;
    endcase
    // Illegal flits leave the state alone, so an open packet still needs its TAIL.
    if (!xfer || !legal) state_nxt = state;
  end

  assign accept = xfer && legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FR_IDLE;
      err_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_drop <= xfer && !legal;
    end
  end
endmodule

// File: rtl/flit_input_buffer.sv
// Per-port input flit FIFO feeding one reductor leg; drops mis-framed flits
// while still completing their handshake so the link never stalls on them.
module flit_input_buffer
  import para::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] in,
  input  logic                 in_valid,
  output logic                 in_avail,
  output logic [FLIT_SIZE-1:0] out,
  output logic                 out_valid,
  input  logic                 out_avail,
  output logic [PTR_W:0]       count,
  output logic                 err_drop
);
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic                 in_xfer, accept, wr_en, rd_en;

  // Full blocks input even when a read frees a slot this cycle.
  assign in_avail  = (count != FULL);
  assign out_valid = (count != '0);
  assign out       = mem[rd_ptr];

  assign in_xfer = in_valid && in_avail;
  assign wr_en   = accept;
  assign rd_en   = out_valid && out_avail;

  flit_frame_checker u_frame (
    .clk       (clk),
    .rst       (rst),
    .flit_type (in[FLIT_SIZE-1 -: HEADER_LEN]),
    .xfer      (in_xfer),
    .accept    (accept),
    .err_drop  (err_drop)
  );

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
